// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl
//   Write/read controller for a (KER_SIZE+1)-row line-buffer array. Incoming
//   raster pixels are written into a rotating row. Once KER_SIZE rows hold
//   data, every new write also reads the other KER_SIZE rows at the same
//   column, so the array's q output presents one vertical kernel window per
//   cycle. After the last pixel, one row of zeros is flushed through to emit
//   the final window row.
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   start            : frame start request (sampled in IDLE only)
//   in_valid/in_ready/in_data : pixel stream, raster order
//   a, wen, ren, d   : row-array address, per-row write/read enables, write data
//   win_valid        : array q output holds a valid window this cycle
//   win_col          : column of that window
//   frame_done       : one-cycle pulse at end of frame
module line_buffer_ctrl #(
  parameter int KER_SIZE = 3,
  parameter int DW       = 32,
  parameter int NW       = 32,
  parameter int AW       = $clog2(NW),
  parameter int IMG_W    = 32,
  parameter int IMG_H    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  output logic [AW-1:0]     a,
  output logic [KER_SIZE:0] wen,
  output logic [KER_SIZE:0] ren,
  output logic [DW-1:0]     d,
  output logic              win_valid,
  output logic [AW-1:0]     win_col,
  output logic              frame_done
);

  localparam int RW = $clog2(KER_SIZE + 1);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    STREAM,
    FLUSH,
    DONE
  } state_t;

  state_t            state, state_nxt;
  logic [AW-1:0]     col;
  logic [15:0]       row;
  logic [RW-1:0]     wr_row;
  logic [AW-1:0]     a_q;
  logic              accept;
  logic              col_last;
  logic [KER_SIZE:0] row_onehot;

  assign col_last   = (col == AW'(IMG_W - 1));
  assign row_onehot = {{KER_SIZE{1'b0}}, 1'b1} << wr_row;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FILL;
      FILL:    if (accept && col_last && row == 16'(KER_SIZE - 1)) state_nxt = STREAM;
      STREAM:  if (accept && col_last && row == 16'(IMG_H - 1))    state_nxt = FLUSH;
      FLUSH:   if (col_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready   = (state == FILL) || (state == STREAM);
    accept     = in_ready && in_valid;
    frame_done = (state == DONE);
    a          = a_q;
    d          = '0;
    wen        = '0;
    ren        = '0;
    if (accept) begin
      a   = col;
      d   = in_data;
      wen = row_onehot;
      if (state == STREAM) ren = ~row_onehot;
    end else if (state == FLUSH) begin
      a   = col;
      wen = row_onehot;
      ren = ~row_onehot;
    end
  end

  // Counters. During FLUSH the column counter doubles as the flush count;
  // row is left alone there so it never passes IMG_H.
  always_ff @(posedge clk) begin
    if (rst) begin
      col    <= '0;
      row    <= '0;
      wr_row <= '0;
    end else if (state == DONE) begin
      col    <= '0;
      row    <= '0;
      wr_row <= '0;
    end else if (accept || state == FLUSH) begin
      if (col_last) begin
        col    <= '0;
        wr_row <= (wr_row == RW'(KER_SIZE)) ? '0 : wr_row + 1'b1;
        if (accept) row <= row + 16'd1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // One-cycle array read latency: window qualifiers follow the read by a cycle.
  // a_q also provides the hold value of a on idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      win_valid <= 1'b0;
    end else begin
      a_q       <= a;
      win_valid <= |ren;
    end
  end

  assign win_col = a_q;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl with KER_SIZE=3, IMG_W=4, IMG_H=5.
module tb_line_buffer_ctrl;

  localparam int KS = 3;
  localparam int DW = 32;
  localparam int NW = 32;
  localparam int AW = 5;
  localparam int W  = 4;
  localparam int H  = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [AW-1:0] a;
  logic [KS:0]   wen;
  logic [KS:0]   ren;
  logic [DW-1:0] d;
  logic          win_valid;
  logic [AW-1:0] win_col;
  logic          frame_done;

  line_buffer_ctrl #(
    .KER_SIZE(KS), .DW(DW), .NW(NW), .AW(AW), .IMG_W(W), .IMG_H(H)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .a(a), .wen(wen), .ren(ren), .d(d),
    .win_valid(win_valid), .win_col(win_col), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned win_cnt = 0;
  logic [KS:0]   prev_ren = '0;
  logic [AW-1:0] prev_a   = '0;
  logic [AW-1:0] last_a   = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge with inputs already driven: checks this cycle's
  // outputs, updates the one-cycle-delayed window expectations, advances.
  task automatic tick(input logic [KS:0] ew, input logic [KS:0] er,
                      input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                      input logic erdy, input logic efd, input string tag);
    #1;
    check({tag, ".in_ready"}, in_ready, erdy);
    check({tag, ".wen"}, wen, ew);
    check({tag, ".ren"}, ren, er);
    check({tag, ".a"}, a, ea);
    check({tag, ".d"}, d, ed);
    check({tag, ".frame_done"}, frame_done, efd);
    check({tag, ".win_valid"}, win_valid, |prev_ren);
    if (|prev_ren) check({tag, ".win_col"}, win_col, prev_a);
    if (win_valid) win_cnt++;
    prev_ren = er;
    prev_a   = ea;
    last_a   = ea;
    @(negedge clk);
  endtask

  // Runs a frame from IDLE. Stops early (returning in FILL/STREAM) after
  // stop_at accepted pixels when stop_at < W*H.
  task automatic run_frame(input bit gaps, input bit start_in_stream, input int stop_at);
    logic [KS:0] ew, er;
    int r, c;
    win_cnt  = 0;
    start    = 1'b1;
    in_valid = 1'b0;
    tick('0, '0, last_a, '0, 1'b0, 1'b0, "start");
    start = 1'b0;
    for (int i = 0; i < W * H; i++) begin
      if (i == stop_at) return;
      r  = i / W;
      c  = i % W;
      ew = 4'b0001 << (r % (KS + 1));
      er = (r >= KS) ? ~ew : 4'b0000;
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          in_valid = 1'b0;
          start    = start_in_stream && (r >= KS);
          tick('0, '0, last_a, '0, 1'b1, 1'b0, "gap");
        end
      end
      in_valid = 1'b1;
      in_data  = 32'hA000 + i;
      start    = start_in_stream && (r >= KS);
      tick(ew, er, AW'(c), in_data, 1'b1, 1'b0, "pix");
    end
    in_valid = 1'b0;
    start    = 1'b0;
    for (int k = 0; k < W; k++)
      tick(4'b0010, 4'b1101, AW'(k), '0, 1'b0, 1'b0, "flush");
    tick('0, '0, last_a, '0, 1'b0, 1'b1, "done");
    tick('0, '0, last_a, '0, 1'b0, 1'b0, "idle_after");
    check("win_count", win_cnt, (H - KS + 1) * W);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    start    = 1'b0;
    @(negedge clk);
    rst      = 1'b0;
    prev_ren = '0;
    prev_a   = '0;
    last_a   = '0;
    #1;
    check("rst.win_col", win_col, '0);
    #4;
    @(negedge clk);
    prev_ren = '0;
  endtask

  initial begin
    // Initial reset, then first cycle out of reset
    @(negedge clk);
    rst = 1'b0;
    tick('0, '0, '0, '0, 1'b0, 1'b0, "rst0");

    // Idle with in_valid high: nothing accepted
    in_valid = 1'b1;
    in_data  = 32'h5555_AAAA;
    for (int i = 0; i < 5; i++) tick('0, '0, '0, '0, 1'b0, 1'b0, "idle");
    in_valid = 1'b0;

    // Clean frame, then frame with random gaps
    run_frame(1'b0, 1'b0, W * H);
    run_frame(1'b1, 1'b0, W * H);

    // Reset mid-frame at row 3, col 2
    run_frame(1'b0, 1'b0, 14);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst      = 1'b0;
    prev_ren = '0;
    last_a   = '0;
    #1;
    check("midrst.win_col", win_col, '0);
    #4;
    @(negedge clk);
    tick('0, '0, '0, '0, 1'b0, 1'b0, "midrst");
    run_frame(1'b0, 1'b0, W * H);

    // start held during STREAM must be ignored
    run_frame(1'b1, 1'b1, W * H);

    do_reset();
    tick('0, '0, '0, '0, 1'b0, 1'b0, "final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1);
  end

endmodule
